// File: rtl/ca3_assoc_memory.sv
// Theta-gated auto-associative memory: Hebbian learning at theta peaks, iterative recall at troughs.
// Define CA3_WEIGHT_DECAY_EN to decrement half-active pairs during learning (anti-Hebbian forgetting).
module ca3_assoc_memory #(
  parameter int WIDTH      = 18,
  parameter int FRAC       = 14,
  parameter int N_UNITS    = 6,
  parameter int W_BITS     = 4,
  parameter int PEAK_THR   = 12288,
  parameter int TROUGH_THR = 12288,
  parameter int RECALL_THR = 2,
  parameter int MAX_ITERS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic signed [WIDTH-1:0]    theta_x,
  input  logic [N_UNITS-1:0]         pattern_in,
  output logic [N_UNITS-1:0]         phase_pattern,
  output logic                       learning,
  output logic                       recalling,
  output logic                       recall_done,
  output logic [3:0]                 debug_state,
  input  logic [$clog2(N_UNITS)-1:0] wt_rd_i,
  input  logic [$clog2(N_UNITS)-1:0] wt_rd_j,
  output logic [W_BITS-1:0]          wt_rd_data
);

  localparam int RW = $clog2(N_UNITS);
  localparam int AW = W_BITS + RW;

  localparam logic signed [WIDTH-1:0] PeakThr   = WIDTH'(PEAK_THR);
  localparam logic signed [WIDTH-1:0] TroughThr = WIDTH'(-TROUGH_THR);
  localparam logic [AW-1:0]           RecallThr = AW'(RECALL_THR);
  localparam logic [3:0]              MaxIters  = 4'(MAX_ITERS);
  localparam logic [RW-1:0]           LastRow   = RW'(N_UNITS - 1);
  localparam logic [RW:0]             NUnits    = (RW + 1)'(N_UNITS);
  localparam logic [W_BITS-1:0]       WMax      = '1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLearn  = 2'd1;
  localparam logic [1:0] StRecall = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               learn_armed_q, learn_armed_d;
  logic               recall_armed_q, recall_armed_d;
  logic [N_UNITS-1:0] lpat_q, lpat_d;
  logic [N_UNITS-1:0] cue_q, cue_d;
  logic [N_UNITS-1:0] cur_q, cur_d;
  logic [RW-1:0]      r_q, r_d;
  logic [3:0]         iter_q, iter_d;
  logic [N_UNITS-1:0] phase_q, phase_d;
  logic               learning_q, recalling_q, recall_done_q;
  logic [W_BITS-1:0]  w_q [N_UNITS][N_UNITS];
  logic [W_BITS-1:0]  w_d [N_UNITS][N_UNITS];

  logic [AW-1:0]      act [N_UNITS];
  logic [N_UNITS-1:0] nxt;
  logic               theta_neg, theta_pos;

  assign theta_neg = theta_x[WIDTH-1];
  assign theta_pos = !theta_x[WIDTH-1] && (theta_x != '0);

  // Activation of every unit from the currently active set; the cue stays clamped on.
  always_comb begin
    for (int j = 0; j < N_UNITS; j++) begin
      act[j] = '0;
      for (int i = 0; i < N_UNITS; i++) begin
        if (cur_q[i]) act[j] = act[j] + AW'(w_q[i][j]);
      end
      nxt[j] = cue_q[j] | (act[j] >= RecallThr);
    end
  end

  always_comb begin
    state_d        = state_q;
    learn_armed_d  = learn_armed_q | theta_neg;
    recall_armed_d = recall_armed_q | theta_pos;
    lpat_d         = lpat_q;
    cue_d          = cue_q;
    cur_d          = cur_q;
    r_d            = r_q;
    iter_d         = iter_q;
    phase_d        = phase_q;
    w_d            = w_q;
    case (state_q)
      StIdle: begin
        if (learn_armed_q && (theta_x >= PeakThr) && (pattern_in != '0)) begin
          state_d       = StLearn;
          lpat_d        = pattern_in;
          r_d           = '0;
          learn_armed_d = 1'b0;
        end else if (recall_armed_q && (theta_x <= TroughThr) && (pattern_in != '0)) begin
          state_d        = StRecall;
          cue_d          = pattern_in;
          cur_d          = pattern_in;
          iter_d         = '0;
          recall_armed_d = 1'b0;
        end
      end
      StLearn: begin
        // Row r owns only the pairs (r, j>r), so each symmetric pair changes once per event.
        for (int i = 0; i < N_UNITS; i++) begin
          for (int j = 0; j < N_UNITS; j++) begin
            if ((i < j) && (int'(r_q) == i)) begin
              if (lpat_q[i] && lpat_q[j]) begin
                if (w_q[i][j] != WMax) begin
                  w_d[i][j] = w_q[i][j] + 1'b1;
                  w_d[j][i] = w_q[i][j] + 1'b1;
                end
              end
`ifdef CA3_WEIGHT_DECAY_EN
              else if (lpat_q[i] ^ lpat_q[j]) begin
                if (w_q[i][j] != '0) begin
                  w_d[i][j] = w_q[i][j] - 1'b1;
                  w_d[j][i] = w_q[i][j] - 1'b1;
                end
              end
`endif
            end
          end
        end
        r_d = r_q + 1'b1;
        if (r_q == LastRow) state_d = StIdle;
      end
      StRecall: begin
        iter_d = iter_q + 4'd1;
        if ((nxt == cur_q) || (iter_d >= MaxIters)) begin
          state_d = StDone;
        end else begin
          cur_d = nxt;
        end
      end
      StDone: begin
        phase_d = cur_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      learn_armed_q  <= 1'b0;
      recall_armed_q <= 1'b0;
      lpat_q         <= '0;
      cue_q          <= '0;
      cur_q          <= '0;
      r_q            <= '0;
      iter_q         <= '0;
      phase_q        <= '0;
      learning_q     <= 1'b0;
      recalling_q    <= 1'b0;
      recall_done_q  <= 1'b0;
      for (int i = 0; i < N_UNITS; i++) begin
        for (int j = 0; j < N_UNITS; j++) begin
          w_q[i][j] <= '0;
        end
      end
    end else begin
      recall_done_q <= clk_en && (state_q == StDone);
      if (clk_en) begin
        state_q        <= state_d;
        learn_armed_q  <= learn_armed_d;
        recall_armed_q <= recall_armed_d;
        lpat_q         <= lpat_d;
        cue_q          <= cue_d;
        cur_q          <= cur_d;
        r_q            <= r_d;
        iter_q         <= iter_d;
        phase_q        <= phase_d;
        learning_q     <= (state_d == StLearn);
        recalling_q    <= (state_d == StRecall);
        w_q            <= w_d;
      end
    end
  end

  // Out-of-range addresses (non power-of-two N_UNITS) read as zero.
  always_comb begin
    wt_rd_data = '0;
    if (({1'b0, wt_rd_i} < NUnits) && ({1'b0, wt_rd_j} < NUnits)) begin
      wt_rd_data = w_q[wt_rd_i][wt_rd_j];
    end
  end

  assign phase_pattern = phase_q;
  assign learning      = learning_q;
  assign recalling     = recalling_q;
  assign recall_done   = recall_done_q;
  assign debug_state   = {learn_armed_q, recall_armed_q, state_q};

endmodule

// File: tb/tb_ca3_assoc_memory.sv
// Randomized scoreboard bench for ca3_assoc_memory with a behavioural weight/recall model.
module tb_ca3_assoc_memory;

  localparam int N      = 6;
  localparam int WB     = 4;
  localparam int MAXIT  = 4;
  localparam int WMAX   = 15;
  localparam int PEAK   = 12288;
  localparam int TROUGH = 12288;
  localparam int RTHR   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clk_en = 1'b0;
  logic signed [17:0] theta_x = '0;
  logic [N-1:0]       pattern_in = '0;
  logic [N-1:0]       phase_pattern;
  logic               learning, recalling, recall_done;
  logic [3:0]         debug_state;
  logic [2:0]         wt_rd_i = '0;
  logic [2:0]         wt_rd_j = '0;
  logic [WB-1:0]      wt_rd_data;

  always #5 clk = ~clk;

  ca3_assoc_memory dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .theta_x      (theta_x),
    .pattern_in   (pattern_in),
    .phase_pattern(phase_pattern),
    .learning     (learning),
    .recalling    (recalling),
    .recall_done  (recall_done),
    .debug_state  (debug_state),
    .wt_rd_i      (wt_rd_i),
    .wt_rd_j      (wt_rd_j),
    .wt_rd_data   (wt_rd_data)
  );

  typedef struct {
    logic [N-1:0] pat;
    int           iters;
  } rexp_t;

  int    lq[$];
  rexp_t rq[$];
  int    mw [N][N];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: whole learn event and whole recall computed in one go.
  function automatic void model_learn(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (p[i] && p[j]) begin
          if (mw[i][j] < WMAX) mw[i][j] = mw[i][j] + 1;
        end
`ifdef CA3_WEIGHT_DECAY_EN
        else if (p[i] != p[j]) begin
          if (mw[i][j] > 0) mw[i][j] = mw[i][j] - 1;
        end
`endif
        mw[j][i] = mw[i][j];
      end
    end
  endfunction

  function automatic void model_recall(input logic [N-1:0] cue, output logic [N-1:0] res,
                                       output int iters);
    logic [N-1:0] cur;
    logic [N-1:0] nx;
    int           a;
    cur   = cue;
    iters = 0;
    for (int it = 1; it <= MAXIT; it++) begin
      for (int j = 0; j < N; j++) begin
        a = 0;
        for (int i = 0; i < N; i++) if (cur[i]) a = a + mw[i][j];
        nx[j] = cue[j] | (a >= RTHR);
      end
      iters = it;
      if ((nx == cur) || (it == MAXIT)) break;
      cur = nx;
    end
    res = cur;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mw[i][j] = 0;
  endfunction

  // Monitor: counts strobes spent in LEARN/RECALL and scores each completed recall.
  int   lcnt = 0, rcnt = 0, rsaved = 0;
  logic prev_l = 1'b0, prev_r = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    rexp_t e;
    if (rst) begin
      lcnt = 0; rcnt = 0; prev_l = 1'b0; prev_r = 1'b0; prev_done = 1'b0;
      lq.delete();
      rq.delete();
    end else begin
      if (prev_done) check("recall_done_width", int'(recall_done), 0);
      if (learning && clk_en) lcnt++;
      if (recalling && clk_en) rcnt++;
      if (prev_l && !learning) begin
        check("learn_expected", int'(lq.size() != 0), 1);
        if (lq.size() != 0) check("learn_strobes", lcnt, lq.pop_front());
        lcnt = 0;
      end
      if (prev_r && !recalling) begin
        rsaved = rcnt;
        rcnt   = 0;
      end
      if (recall_done) begin
        check("recall_expected", int'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
          e = rq.pop_front();
          check("recall_pattern", int'(phase_pattern), int'(e.pat));
          check("recall_iters", rsaved, e.iters);
        end
      end
      prev_l    = learning;
      prev_r    = recalling;
      prev_done = recall_done;
    end
  end

  task automatic strobe();
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      clk_en = 1'b0;
      @(posedge clk);
      #1;
    end
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
  endtask

  task automatic read_w(input int i, input int j, output int v);
    wt_rd_i = 3'(i);
    wt_rd_j = 3'(j);
    #1;
    v = int'(wt_rd_data);
  endtask

  task automatic check_weights(input string tag);
    int v;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        read_w(i, j, v);
        check($sformatf("%s_w%0d%0d", tag, i, j), v, mw[i][j]);
      end
    end
  endtask

  // One theta cycle: small negative, peak (learn lp), small positive, trough (recall cue).
  task automatic theta_cycle(input logic [N-1:0] lp, input logic [N-1:0] cue, input bit fixed,
                             input logic [N-1:0] fpat, input int fit);
    rexp_t e;
    int    rit;
    logic [N-1:0] rpat;
    theta_x    = -18'sd100;
    pattern_in = '0;
    repeat (2) strobe();
    theta_x    = 18'(PEAK + int'($urandom_range(0, 100000)));
    pattern_in = lp;
    if (lp != '0) begin
      model_learn(lp);
      lq.push_back(N);
    end
    strobe();
    if (lp != '0) pattern_in = N'($urandom);
    repeat (N + 2) strobe();
    theta_x    = 18'sd100;
    pattern_in = '0;
    repeat (2) strobe();
    theta_x    = 18'(-TROUGH - int'($urandom_range(0, 100000)));
    pattern_in = cue;
    if (cue != '0) begin
      model_recall(cue, rpat, rit);
      e.pat   = fixed ? fpat : rpat;
      e.iters = fixed ? fit : rit;
      rq.push_back(e);
    end
    strobe();
    if (cue != '0) pattern_in = N'($urandom);
    repeat (MAXIT + 3) strobe();
    pattern_in = '0;
  endtask

  initial begin
    int v;
    model_clear();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_phase", int'(phase_pattern), 0);
    check("rst_learning", int'(learning), 0);
    check("rst_recalling", int'(recalling), 0);
    check("rst_recall_done", int'(recall_done), 0);
    check("rst_debug", int'(debug_state), 0);
    check_weights("rst");

    repeat (24) theta_cycle('0, '0, 1'b0, '0, 0);
    check("warm_learning", int'(learning), 0);
    check("warm_recalling", int'(recalling), 0);
    check("warm_phase", int'(phase_pattern), 0);
    check_weights("warm");

    repeat (5) theta_cycle(6'b101010, '0, 1'b0, '0, 0);
    read_w(5, 3, v); check("w53_x5", v, 5);
    read_w(3, 1, v); check("w31_x5", v, 5);
    read_w(1, 5, v); check("w15_x5", v, 5);
    read_w(5, 4, v); check("w54_x5", v, 0);

    for (int k = 0; k < 5; k++) begin
      theta_cycle(6'b010101, (k == 4) ? 6'b100000 : 6'b000000, 1'b1, 6'b101010, 2);
    end
    check("phase_cue_100000", int'(phase_pattern), int'(6'b101010));
    theta_cycle('0, 6'b000001, 1'b1, 6'b010101, 2);
    check("phase_cue_000001", int'(phase_pattern), int'(6'b010101));
    check_weights("dir");

    for (int k = 0; k < 40; k++) begin
      theta_cycle(N'($urandom), N'($urandom), 1'b0, '0, 0);
      check_weights("rand");
    end

    repeat (20) theta_cycle(6'b101010, '0, 1'b0, '0, 0);
    read_w(5, 3, v); check("w53_sat", v, WMAX);
    check_weights("sat");

    // Abort a learn event part-way through with reset.
    theta_x    = -18'sd100;
    pattern_in = '0;
    repeat (2) strobe();
    theta_x    = 18'sd20000;
    pattern_in = 6'b101010;
    strobe();
    pattern_in = '0;
    repeat (2) strobe();
    check("learning_pre_rst", int'(learning), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check("learning_post_rst", int'(learning), 0);
    check("debug_post_rst", int'(debug_state), 0);
    check_weights("midrst");

    repeat (3) theta_cycle(6'b110000, '0, 1'b0, '0, 0);
    theta_cycle(6'b100000, '0, 1'b0, '0, 0);
    read_w(5, 4, v);
`ifdef CA3_WEIGHT_DECAY_EN
    check("w54_decay", v, 2);
`else
    check("w54_nodecay", v, 3);
`endif
    check_weights("final");

    repeat (5) strobe();
    check("learn_q_drained", lq.size(), 0);
    check("recall_q_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
